// File: rtl/conv_fmap_capture.sv
// conv_fmap_capture
// Captures one FMAP_W x FMAP_H feature map from a free-running conv output
// stream into internal RAM, then drains it in raster order over valid/ready.
// Optional build macro CONV_CAP_CLIP_EN: clip oversize non-negative samples
// to all ones and raise sat_flag; without it samples are truncated (wrap).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for cap_start; stream samples are dropped
// S_CAPTURE | writing each valid sample to RAM[wr_cnt]
// S_FULL    | frame stored, waiting for rd_start
// S_DRAIN   | streaming RAM out through prefetch + output register
module conv_fmap_capture #(
    parameter int DATA_W  = 32,
    parameter int STORE_W = 16,
    parameter int FMAP_W  = 24,
    parameter int FMAP_H  = 24,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    input  logic               cap_start,
    input  logic               rd_start,
    output logic [STORE_W-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               frame_done,
    output logic               drop_err,
    output logic               sat_flag
);
    localparam int N = FMAP_W * FMAP_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0]  rd_cnt;
    logic               rd_all;     // every address of the frame has been read
    logic [STORE_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [STORE_W-1:0] ram_q;      // synchronous RAM read data (prefetch stage)
    logic               q_vld;
    logic               q_last;
    logic [STORE_W-1:0] conv_data;

    logic cap_go;
    logic rd_go;
    logic wr_en;
    logic out_take;
    logic q_adv;
    logic rd_en;
    logic last_hs;

    assign cap_go   = (state == S_IDLE) && cap_start;
    assign rd_go    = (state == S_FULL) && rd_start;
    assign wr_en    = (state == S_CAPTURE) && s_valid;
    // output register can accept a new sample this cycle
    assign out_take = !m_valid || m_ready;
    assign q_adv    = q_vld && out_take;
    // issue a read whenever the prefetch stage will be empty after this edge
    assign rd_en    = rd_go || ((state == S_DRAIN) && !rd_all && (!q_vld || q_adv));
    assign last_hs  = (state == S_DRAIN) && m_valid && m_ready && m_last;
    assign busy     = (state != S_IDLE);

    // Sample conversion: negative sums become 0, otherwise truncate or clip
`ifdef CONV_CAP_CLIP_EN
    logic conv_sat;

    always_comb begin
        conv_data = s_data[STORE_W-1:0];
        conv_sat  = 1'b0;
        if (s_data[DATA_W-1]) begin
            conv_data = '0;
        end else if (|s_data[DATA_W-2:STORE_W]) begin
            conv_data = '1;
            conv_sat  = 1'b1;
        end
    end

    // Sticky saturation flag, cleared when a new capture is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (cap_go)
            sat_flag <= 1'b0;
        else if (wr_en && conv_sat)
            sat_flag <= 1'b1;
    end
`else
    logic unused_hi;

    assign unused_hi = ^s_data[DATA_W-2:STORE_W];

    always_comb begin
        conv_data = s_data[STORE_W-1:0];
        if (s_data[DATA_W-1])
            conv_data = '0;
    end

    assign sat_flag = 1'b0;
`endif

    // Frame storage: write port in capture, registered read port for drain
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_cnt] <= conv_data;
        if (rd_en)
            ram_q <= mem[rd_cnt];
    end

    // Control FSM, counters, prefetch tracking and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_all     <= 1'b0;
            q_vld      <= 1'b0;
            q_last     <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // a sample arriving together with cap_start still counts as a drop
            if (cap_go)
                drop_err <= 1'b0;
            if (s_valid && (state != S_CAPTURE))
                drop_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cap_start) begin
                        state  <= S_CAPTURE;
                        wr_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (s_valid) begin
                        if (wr_cnt == LAST_ADDR) begin
                            wr_cnt     <= '0;
                            state      <= S_FULL;
                            frame_done <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (rd_start)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (last_hs)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (rd_en) begin
                q_vld  <= 1'b1;
                q_last <= (rd_cnt == LAST_ADDR);
                rd_all <= (rd_cnt == LAST_ADDR);
                rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
            end else if (q_adv) begin
                q_vld <= 1'b0;
            end

            // output register only moves when empty or on a handshake
            if ((state == S_DRAIN) && out_take) begin
                m_valid <= q_vld;
                m_last  <= q_vld && q_last;
                if (q_vld)
                    m_data <= ram_q;
            end

            if (last_hs) begin
                rd_all <= 1'b0;
                rd_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conv_fmap_capture.sv
// Self-checking bench for conv_fmap_capture: random frames are converted by a
// plain arithmetic model into an expected sample list, then drained and compared.
module tb_conv_fmap_capture;
    localparam int N = 24 * 24;
`ifdef CONV_CAP_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        cap_start = 1'b0;
    logic        rd_start = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_valid, m_last, busy, frame_done, drop_err, sat_flag;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    bit          exp_sat;

    always #5 clk = ~clk;

    conv_fmap_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .cap_start  (cap_start),
        .rd_start   (rd_start),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_err   (drop_err),
        .sat_flag   (sat_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_store(input logic [31:0] d);
        longint v = longint'($signed(d));
        if (v < 0) return 16'h0;
        if (CLIP && v > 65535) return 16'hFFFF;
        return 16'(v % 65536);
    endfunction

    function automatic bit ref_sat(input logic [31:0] d);
        longint v = longint'($signed(d));
        return CLIP && (v > 65535);
    endfunction

    function automatic logic [31:0] gen(input int mode, input int i);
        if (mode == 0) return 32'(i);
        if (mode == 2) begin
            if (i == 0) return 32'hFFFF_FF00;
            if (i == 1) return 32'h0001_2345;
            return 32'(i);
        end
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'($urandom_range(0, 65535));
            2: return 32'h0001_0000 + 32'($urandom_range(0, 255));
            default: return 32'h8000_0000 | $urandom();
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_last"}, 32'(m_last), 0);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_drop_err"}, 32'(drop_err), 0);
        check({tag, "_sat_flag"}, 32'(sat_flag), 0);
    endtask

    // Arms a capture and feeds N samples; abort_at >= 0 asserts reset at that sample
    task automatic capture(input int mode, input int gap, input bit v_with_start,
                           input bit rd_mid, input int abort_at);
        bit fd_bad = 0;
        bit busy_bad = 0;
        exp_q.delete();
        exp_sat = 0;
        @(negedge clk);
        cap_start = 1'b1;
        if (v_with_start) begin
            s_valid = 1'b1;
            s_data  = 32'h0000_1234;
        end
        @(negedge clk);
        cap_start = 1'b0;
        s_valid   = 1'b0;
        check(v_with_start ? "drop_with_start" : "drop_cleared", 32'(drop_err), 32'(v_with_start));
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort_reset");
                return;
            end
            s_valid = 1'b1;
            s_data  = gen(mode, i);
            exp_q.push_back(ref_store(s_data));
            if (ref_sat(s_data)) exp_sat = 1;
            rd_start = rd_mid && (i == 100);
            @(negedge clk);
            s_valid  = 1'b0;
            rd_start = 1'b0;
            if (frame_done !== (i == N - 1)) fd_bad = 1;
            if (!busy || m_valid) busy_bad = 1;
            if (i < N - 1) repeat (gap) @(negedge clk);
        end
        check("frame_done_timing", 32'(fd_bad), 0);
        check("busy_capture", 32'(busy_bad), 0);
        @(negedge clk);
        check("frame_done_single", 32'(frame_done), 0);
        check("busy_full", 32'(busy), 1);
        check("m_valid_full", 32'(m_valid), 0);
        check("sat_flag", 32'(sat_flag), 32'(exp_sat));
        check("drop_err_capture", 32'(drop_err), 32'(v_with_start));
    endtask

    // Pulses rd_start (optionally with cap_start) and collects the drained frame
    task automatic drain(input bit rnd, input bit with_cap);
        int   idx = 0;
        int   cyc = 0;
        int   first = -1;
        bit   stalled = 0, stab_bad = 0, last_bad = 0, busy_bad = 0;
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        @(negedge clk);
        rd_start  = 1'b1;
        cap_start = with_cap;
        m_ready   = 1'b0;
        while (idx < N && cyc < 4 * N + 20) begin
            @(negedge clk);
            cyc++;
            rd_start  = 1'b0;
            cap_start = 1'b0;
            if (stalled && (!m_valid || m_data !== pd || m_last !== pl)) stab_bad = 1;
            if (!busy) busy_bad = 1;
            if (m_valid && first < 0) first = cyc;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                check("drain_data", 32'(m_data), 32'(exp_q[idx]));
                if (m_last !== (idx == N - 1)) last_bad = 1;
                idx++;
            end
            stalled = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
        end
        check("drain_count", 32'(idx), 32'(N));
        check("m_valid_latency", 32'(first), 2);
        check("stall_stable", 32'(stab_bad), 0);
        check("m_last_position", 32'(last_bad), 0);
        check("busy_drain", 32'(busy_bad), 0);
        @(negedge clk);
        m_ready = 1'b0;
        check("m_valid_after_last", 32'(m_valid), 0);
        check("busy_after_last", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ramp frame, continuous valid, ready held high
        capture(0, 0, 0, 0, -1);
        drain(0, 0);

        // ramp frame with 1-on/2-off valid gaps
        capture(0, 2, 0, 0, -1);
        drain(0, 0);

        // random data, random ready
        capture(1, 0, 0, 0, -1);
        drain(1, 0);

        // negative and oversize corner samples; cap_start ignored alongside rd_start
        capture(2, 1, 0, 0, -1);
        drain(1, 1);

        // drop in IDLE, rd_start in IDLE ignored
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h0000_0055;
        @(negedge clk);
        s_valid  = 1'b0;
        rd_start = 1'b1;
        check("drop_idle", 32'(drop_err), 1);
        @(negedge clk);
        rd_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_start_idle_valid", 32'(m_valid), 0);
        check("rd_start_idle_busy", 32'(busy), 0);

        // valid with cap_start dropped, rd_start mid-capture ignored
        capture(1, 0, 1, 1, -1);
        drain(1, 0);

        // reset at sample 300, then a fresh frame
        capture(1, 0, 0, 0, 300);
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h0000_0001;
        @(negedge clk);
        s_valid = 1'b0;
        check("post_reset_no_capture", 32'(busy), 0);
        check("post_reset_drop", 32'(drop_err), 1);
        capture(1, 1, 0, 0, -1);
        drain(1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
